// File: rtl/fpga_cfg_seq.sv
// Passive-serial configuration sequencer for an ACEX1K FPGA: timed nCONFIG, byte-fed DCLK/DATA0.
// Optional: define CFG_TIMEOUT_EN to bound the WSTAT/WINIT waits by WAIT_TMO cycles.
module fpga_cfg_seq #(
    parameter int unsigned NCFG_LOW   = 16,
    parameter int unsigned DCLK_HALF  = 1,
    parameter int unsigned EXTRA_CLKS = 10,
    parameter int unsigned WAIT_TMO   = 1023
) (
    input  logic       clkin,
    input  logic       coldres_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_stb,
    output logic       din_rdy,
    output logic       config_n,
    input  logic       status_n,
    input  logic       conf_done,
    input  logic       init_done,
    output logic       dclk,
    output logic       data0,
    output logic [3:0] cfg_state,
    output logic       cfg_ok,
    output logic       cfg_err
);

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLow   = 4'd1,
        StWstat = 4'd2,
        StLoad  = 4'd3,
        StShift = 4'd4,
        StCheck = 4'd5,
        StExtra = 4'd6,
        StWinit = 4'd7,
        StDone  = 4'd8,
        StErr   = 4'd9
    } state_e;

    // One shared counter covers nCONFIG low time, bit index and extra-pulse index.
    localparam int unsigned CntMax = (NCFG_LOW > EXTRA_CLKS) ?
        ((NCFG_LOW > 8) ? NCFG_LOW : 8) : ((EXTRA_CLKS > 8) ? EXTRA_CLKS : 8);
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam int unsigned PhW  = $clog2(2 * DCLK_HALF + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PhW-1:0]    ph_q, ph_d;
    logic [7:0]        sh_q, sh_d;
    logic              config_n_q, config_n_d;
    logic              dclk_q, dclk_d;
    logic              data0_q, data0_d;
    logic              din_rdy_q, din_rdy_d;
    logic              cfg_ok_q, cfg_ok_d;
    logic              cfg_err_q, cfg_err_d;
    logic [1:0]        status_sync_q, conf_sync_q, init_sync_q;
    logic              status_s, conf_s, init_s;
    logic              ph_mid, ph_last, go_low, go_err, tmo_hit;

`ifdef CFG_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(WAIT_TMO + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
    assign tmo_hit = (tmo_q == TmoW'(WAIT_TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign status_s = status_sync_q[1];
    assign conf_s   = conf_sync_q[1];
    assign init_s   = init_sync_q[1];
    assign ph_mid   = (ph_q == PhW'(DCLK_HALF - 1));
    assign ph_last  = (ph_q == PhW'(2 * DCLK_HALF - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ph_d       = ph_q;
        sh_d       = sh_q;
        config_n_d = config_n_q;
        dclk_d     = dclk_q;
        data0_d    = data0_q;
        din_rdy_d  = din_rdy_q;
        cfg_ok_d   = cfg_ok_q;
        cfg_err_d  = cfg_err_q;
        go_low     = 1'b0;
        go_err     = 1'b0;

        // DCLK phase generator shared by SHIFT and EXTRA
        if (state_q == StShift || state_q == StExtra) begin
            ph_d = ph_q + PhW'(1);
            if (ph_mid) dclk_d = 1'b1;
            if (ph_last) begin
                ph_d   = '0;
                dclk_d = 1'b0;
            end
        end

        case (state_q)
            StIdle: if (start) go_low = 1'b1;
            StLow: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(NCFG_LOW - 1)) begin
                    config_n_d = 1'b1;
                    state_d    = StWstat;
                end
            end
            StWstat: begin
                if (status_s) begin
                    din_rdy_d = 1'b1;
                    state_d   = StLoad;
                end else if (tmo_hit) begin
                    go_err = 1'b1;
                end
            end
            StLoad: begin
                if (din_stb && din_rdy_q) begin
                    data0_d   = din[0];
                    sh_d      = {1'b0, din[7:1]};
                    din_rdy_d = 1'b0;
                    dclk_d    = 1'b0;
                    ph_d      = '0;
                    cnt_d     = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (ph_last) begin
                    if (cnt_q == CntW'(7)) begin
                        state_d = StCheck;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        data0_d = sh_q[0];
                        sh_d    = {1'b0, sh_q[7:1]};
                    end
                end
            end
            StCheck: begin
                if (conf_s) begin
                    data0_d = 1'b1;
                    dclk_d  = 1'b0;
                    ph_d    = '0;
                    cnt_d   = '0;
                    state_d = StExtra;
                end else begin
                    din_rdy_d = 1'b1;
                    state_d   = StLoad;
                end
            end
            StExtra: begin
                if (ph_last) begin
                    if (cnt_q == CntW'(EXTRA_CLKS - 1)) state_d = StWinit;
                    else cnt_d = cnt_q + CntW'(1);
                end
            end
            StWinit: begin
                if (init_s) begin
                    cfg_ok_d = 1'b1;
                    state_d  = StDone;
                end else if (tmo_hit) begin
                    go_err = 1'b1;
                end
            end
            StDone:  if (start) go_low = 1'b1;
            StErr:   if (start) go_low = 1'b1;
            default: state_d = StIdle;
        endcase

        // Losing nSTATUS aborts everything, including a half-shifted byte
        if (!status_s && (state_q == StLoad || state_q == StShift || state_q == StCheck ||
                          state_q == StExtra || state_q == StWinit)) begin
            go_err = 1'b1;
        end

        if (go_err) begin
            state_d   = StErr;
            cfg_err_d = 1'b1;
            cfg_ok_d  = 1'b0;
            dclk_d    = 1'b0;
            din_rdy_d = 1'b0;
        end else if (go_low) begin
            state_d    = StLow;
            config_n_d = 1'b0;
            cfg_ok_d   = 1'b0;
            cfg_err_d  = 1'b0;
            dclk_d     = 1'b0;
            din_rdy_d  = 1'b0;
            cnt_d      = '0;
        end

`ifdef CFG_TIMEOUT_EN
        if (state_d != state_q) tmo_d = '0;
        else if (tmo_q == TmoW'(WAIT_TMO)) tmo_d = tmo_q;
        else tmo_d = tmo_q + TmoW'(1);
`endif
    end

    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ph_q          <= '0;
            sh_q          <= '0;
            config_n_q    <= 1'b0;
            dclk_q        <= 1'b0;
            data0_q       <= 1'b0;
            din_rdy_q     <= 1'b0;
            cfg_ok_q      <= 1'b0;
            cfg_err_q     <= 1'b0;
            status_sync_q <= '0;
            conf_sync_q   <= '0;
            init_sync_q   <= '0;
`ifdef CFG_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ph_q          <= ph_d;
            sh_q          <= sh_d;
            config_n_q    <= config_n_d;
            dclk_q        <= dclk_d;
            data0_q       <= data0_d;
            din_rdy_q     <= din_rdy_d;
            cfg_ok_q      <= cfg_ok_d;
            cfg_err_q     <= cfg_err_d;
            status_sync_q <= {status_sync_q[0], status_n};
            conf_sync_q   <= {conf_sync_q[0], conf_done};
            init_sync_q   <= {init_sync_q[0], init_done};
`ifdef CFG_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign cfg_state = state_q;
    assign config_n  = config_n_q;
    assign dclk      = dclk_q;
    assign data0     = data0_q;
    assign din_rdy   = din_rdy_q;
    assign cfg_ok    = cfg_ok_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fpga_cfg_seq.sv
// Scoreboard bench for fpga_cfg_seq: expected DATA0 bits at each DCLK rise are queued by stimulus.
module tb_fpga_cfg_seq;

    localparam int unsigned NCFG_LOW   = 16;
    localparam int unsigned DCLK_HALF  = 1;
    localparam int unsigned EXTRA_CLKS = 10;
    localparam int unsigned WAIT_TMO   = 1023;

    logic       clkin = 1'b0;
    logic       coldres_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_stb = 1'b0;
    logic       status_n = 1'b0;
    logic       conf_done = 1'b0;
    logic       init_done = 1'b0;
    logic       din_rdy, config_n, dclk, data0, cfg_ok, cfg_err;
    logic [3:0] cfg_state;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];
    bit prev_dclk = 1'b0;

    fpga_cfg_seq #(
        .NCFG_LOW   (NCFG_LOW),
        .DCLK_HALF  (DCLK_HALF),
        .EXTRA_CLKS (EXTRA_CLKS),
        .WAIT_TMO   (WAIT_TMO)
    ) dut (
        .clkin     (clkin),
        .coldres_n (coldres_n),
        .start     (start),
        .din       (din),
        .din_stb   (din_stb),
        .din_rdy   (din_rdy),
        .config_n  (config_n),
        .status_n  (status_n),
        .conf_done (conf_done),
        .init_done (init_done),
        .dclk      (dclk),
        .data0     (data0),
        .cfg_state (cfg_state),
        .cfg_ok    (cfg_ok),
        .cfg_err   (cfg_err)
    );

    always #5 clkin = ~clkin;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DCLK rise must match the next queued DATA0 bit
    always @(negedge clkin) begin
        if (!coldres_n) begin
            prev_dclk <= 1'b0;
        end else begin
            if (dclk && !prev_dclk) begin
                if (exp_q.size() == 0) check("unexpected_dclk_rise", dclk, 1'b0);
                else check("data0_at_dclk_rise", data0, exp_q.pop_front());
            end
            prev_dclk <= dclk;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_config_n"}, config_n, 1'b0);
        check({tag, "_dclk"}, dclk, 1'b0);
        check({tag, "_data0"}, data0, 1'b0);
        check({tag, "_din_rdy"}, din_rdy, 1'b0);
        check({tag, "_cfg_ok"}, cfg_ok, 1'b0);
        check({tag, "_cfg_err"}, cfg_err, 1'b0);
        check({tag, "_state"}, cfg_state, 4'd0);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int k = 0;
        while (cfg_state !== s && k < budget) begin
            k++;
            @(negedge clkin);
        end
        check(name, cfg_state, s);
    endtask

    task automatic do_start(input bit raise_status);
        int low = 0;
        @(negedge clkin);
        start = 1'b1;
        status_n = 1'b0;
        conf_done = 1'b0;
        init_done = 1'b0;
        @(negedge clkin);
        start = 1'b0;
        check("start_state_low", cfg_state, 4'd1);
        check("start_config_n", config_n, 1'b0);
        check("start_cfg_err", cfg_err, 1'b0);
        check("start_cfg_ok", cfg_ok, 1'b0);
        while (config_n === 1'b0 && low < 200) begin
            low++;
            @(negedge clkin);
        end
        check("ncfg_low_cycles", low, NCFG_LOW);
        if (raise_status) begin
            repeat (5) @(negedge clkin);
            status_n = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit garbage, input bit start_mid,
                             input bit last);
        int k = 0;
        while (din_rdy !== 1'b1 && k < 300) begin
            k++;
            @(negedge clkin);
        end
        check("din_rdy_wait", din_rdy, 1'b1);
        if (din_rdy !== 1'b1) return;
        repeat ($urandom_range(0, 3)) @(negedge clkin);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        din = b;
        din_stb = 1'b1;
        @(negedge clkin);
        din_stb = 1'b0;
        check("din_rdy_after_transfer", din_rdy, 1'b0);
        check("state_shift", cfg_state, 4'd4);
        if (garbage) begin
            din = ~b;
            din_stb = 1'b1;
            @(negedge clkin);
            din_stb = 1'b0;
        end
        if (start_mid) begin
            start = 1'b1;
            @(negedge clkin);
            start = 1'b0;
            check("start_in_shift_ignored", cfg_state, 4'd4);
        end
        if (last) begin
            conf_done = 1'b1;
            for (int i = 0; i < EXTRA_CLKS; i++) exp_q.push_back(1'b1);
        end
    endtask

    task automatic finish_config();
        repeat (20) @(negedge clkin);
        init_done = 1'b1;
        wait_state(4'd8, 300, "reach_done");
        check("done_cfg_ok", cfg_ok, 1'b1);
        check("done_cfg_err", cfg_err, 1'b0);
        check("done_dclk", dclk, 1'b0);
        check("done_config_n", config_n, 1'b1);
        check("bits_all_seen", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        int n;
        bit rdy_seen;

        // Reset holds outputs whatever the inputs do
        for (int i = 0; i < 4; i++) begin
            @(negedge clkin);
            {start, din_stb, status_n, conf_done, init_done} = 5'($urandom);
            din = 8'($urandom);
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clkin);
        {start, din_stb, status_n, conf_done, init_done} = '0;
        coldres_n = 1'b1;

        // Nominal load of two fixed bytes
        do_start(1'b1);
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
        finish_config();

        // Random bitstreams, with ignored strobes and ignored starts mixed in
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            do_start(1'b1);
            for (int i = 0; i < n; i++) begin
                send_byte(8'($urandom), ($urandom % 3) == 0, (i == 0) && (r % 2 == 0),
                          i == n - 1);
            end
            finish_config();
        end

        // nSTATUS drops during bit 3
        do_start(1'b1);
        send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clkin);
        status_n = 1'b0;
        k = 0;
        while (cfg_state !== 4'd9 && k < 3) begin
            k++;
            @(negedge clkin);
        end
        check("abort_state_err", cfg_state, 4'd9);
        check("abort_dclk", dclk, 1'b0);
        check("abort_cfg_err", cfg_err, 1'b0 + 1'b1);
        check("abort_cfg_ok", cfg_ok, 1'b0);
        check("abort_din_rdy", din_rdy, 1'b0);
        exp_q.delete();
        repeat (20) @(negedge clkin);
        check("err_holds", cfg_state, 4'd9);

        // Restart from ERR, then reset asynchronously while DCLK is high
        do_start(1'b1);
        send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
        k = 0;
        while (dclk !== 1'b1 && k < 20) begin
            k++;
            @(negedge clkin);
        end
        check("dclk_high_before_reset", dclk, 1'b1);
        coldres_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clkin);
        coldres_n = 1'b1;
        @(negedge clkin);
        check("idle_after_reset", cfg_state, 4'd0);

`ifdef CFG_TIMEOUT_EN
        // nSTATUS never rises: WSTAT must give up after WAIT_TMO cycles
        do_start(1'b0);
        k = 0;
        rdy_seen = 1'b0;
        while (cfg_state === 4'd2 && k < 2000) begin
            k++;
            @(negedge clkin);
            rdy_seen |= din_rdy;
        end
        check("wstat_timeout_cycles", k, WAIT_TMO);
        check("timeout_state_err", cfg_state, 4'd9);
        check("timeout_cfg_err", cfg_err, 1'b1);
        check("timeout_no_din_rdy", rdy_seen, 1'b0);
`else
        rdy_seen = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_seq.md
Name: fpga_cfg_seq

Overview:
Passive-serial configuration sequencer for the ACEX1K FPGA on the sound card's control CPLD. It drives nCONFIG, DCLK and DATA0, and watches nSTATUS, CONF_DONE and INIT_DONE. Bitstream bytes arrive from the Z80 port decoder over a ready/strobe byte handshake. It replaces the static nCONFIG latch with a full, timed configuration flow and reports status back to the CPU.

Parameters:
NCFG_LOW, 16, clkin cycles nCONFIG is held low after start
DCLK_HALF, 1, clkin cycles per DCLK phase (low or high); one bit = 2*DCLK_HALF cycles
EXTRA_CLKS, 10, DCLK pulses issued after CONF_DONE is seen
WAIT_TMO, 1023, max cycles in WSTAT or WINIT before error (counter width = clog2(WAIT_TMO+1))

Ports:
clkin  in  1  system clock
coldres_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin configuration
din  in  8  bitstream byte, shifted LSB first
din_stb  in  1  byte valid; a transfer occurs when din_stb && din_rdy
din_rdy  out  1  sequencer can accept a byte
config_n  out  1  FPGA nCONFIG
status_n  in  1  FPGA nSTATUS (asynchronous)
conf_done  in  1  FPGA CONF_DONE (asynchronous)
init_done  in  1  FPGA INIT_DONE (asynchronous)
dclk  out  1  configuration clock
data0  out  1  configuration data
cfg_state  out  4  current state encoding
cfg_ok  out  1  configuration completed
cfg_err  out  1  configuration failed

Behaviour:
- Clocking and reset: one clock (clkin); reset is asynchronous and active-low (coldres_n).
- Reset values: config_n=0, dclk=0, data0=0, din_rdy=0, cfg_ok=0, cfg_err=0, cfg_state=IDLE. An asserted reset at any time, including mid-shift, forces these values immediately.
- Synchronisers: status_n, conf_done and init_done each pass through a 2-flop synchronizer. All decisions use the synchronized values, so an input change is acted on 3 cycles later.
- State encoding: IDLE=0, LOW=1, WSTAT=2, LOAD=3, SHIFT=4, CHECK=5, EXTRA=6, WINIT=7, DONE=8, ERR=9.
- IDLE: outputs hold their values. start -> LOW.
- LOW: config_n=0, cfg_ok=0, cfg_err=0, dclk=0. After NCFG_LOW cycles: config_n=1, go to WSTAT. config_n falls in the cycle after start.
- WSTAT: wait for status_n=1 -> LOAD. Timeout -> ERR.
- LOAD: din_rdy=1. On a transfer, latch din, clear din_rdy, go to SHIFT on the next cycle.
- SHIFT, per bit, LSB first:
  - data0 is set to the bit at the start of the low phase; dclk=0 for DCLK_HALF cycles, then dclk=1 for DCLK_HALF cycles.
  - After 8 bits -> CHECK, with dclk=0.
  - One byte occupies 16*DCLK_HALF cycles.
- CHECK (1 cycle): conf_done=1 -> EXTRA, else -> LOAD.
- EXTRA: EXTRA_CLKS DCLK pulses with data0=1 and the same timing as SHIFT, then -> WINIT.
- WINIT: init_done=1 -> DONE. Timeout -> ERR.
- DONE: cfg_ok=1, dclk=0. start -> LOW.
- ERR: cfg_err=1, dclk=0, din_rdy=0. start -> LOW.
- status_n=0 (synchronized) in LOAD, SHIFT, CHECK, EXTRA or WINIT -> ERR next cycle. This overrides all other transitions, including an in-progress bit and a simultaneous din_stb.
- conf_done seen during SHIFT is ignored until CHECK; the current byte always completes.
- start in LOW through WINIT is ignored.
- din_stb when din_rdy=0 is ignored; no data is latched.
- The timeout counter clears on every state entry and saturates at WAIT_TMO.
- cfg_ok and cfg_err are never both 1.

Optional Feature:
CFG_TIMEOUT_EN
- Defined: WSTAT and WINIT go to ERR when the counter reaches WAIT_TMO.
- Undefined: no counter is synthesized and WSTAT/WINIT wait indefinitely. ERR is then reachable only through status_n=0.

Test Plan:
- Reset values: hold coldres_n=0, toggle all inputs -> config_n=0, dclk=0, data0=0, din_rdy=0, cfg_ok=0, cfg_err=0, cfg_state=0.
- Nominal load, DCLK_HALF=1:
  - Stimulus: start; status_n rises 5 cycles after config_n goes high; send 0xA5 then 0x3C; conf_done rises during the 2nd byte; init_done rises 20 cycles later.
  - Response: config_n low for exactly 16 cycles; data0 at dclk rises = 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; exactly 10 extra dclk pulses with data0=1; cfg_state=8, cfg_ok=1.
- status_n timeout (CFG_TIMEOUT_EN defined): status_n held 0 after LOW -> ERR exactly 1023 cycles after WSTAT entry, cfg_err=1, din_rdy never asserted.
- Mid-shift failure: status_n falls during bit 3 of a byte -> cfg_state=9 within 3 cycles, dclk=0, no further dclk edges.
- Async reset mid-SHIFT: coldres_n pulsed low while dclk=1 -> all outputs take reset values in the same cycle, state IDLE.
- Start handling: start during SHIFT -> ignored, byte completes normally; start in ERR -> config_n=0 next cycle, cfg_err=0, state LOW.
